// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder family.
// - SEG_0..SEG_F: active-low segment patterns {dp,g,f,e,d,c,b,a} with dp off
// - SEG_DP: bit index of the decimal point in a segment byte
// - sel_state_e: digit-select tracking states
package seg_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam int unsigned SEG_DP = 7;

  typedef enum logic [1:0] {
    StWaitSel,
    StSettling,
    StCaptured
  } sel_state_e;

endpackage

// File: rtl/seg_decode_lut.sv
// Combinational inverse of the hex-to-7-segment encoder.
// Ports:
//   pat    in  7  active-low segment lines g..a
//   ok     out 1  pattern is one of the 16 hex glyphs
//   nibble out 4  decoded hex value (0 when ok is low)
module seg_decode_lut
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       ok,
  output logic [3:0] nibble
);

  always_comb begin
    ok     = 1'b1;
    nibble = 4'h0;
    // Patterns are stored with dp off, so look up with bit 7 forced high.
    case ({1'b1, pat})
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the displayed hex value.
// A value is published once STABLE_FRAMES identical, fully decodable frames are seen.
// Ports:
//   clk          in  1         clock
//   rst          in  1         asynchronous active-high reset
//   seg          in  8         segment lines, active-low, bit 7 = dp
//   an           in  DIGITS    digit selects, active-low
//   value        out 4*DIGITS  published value, digit i at [4i+3:4i]
//   dp           out DIGITS    published decimal points, 1 = lit
//   value_valid  out 1         one-cycle pulse when value/dp update
//   bad_pattern  out 1         one-cycle pulse on capture of an undecodable pattern
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SETTLE        = 16,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic                  value_valid,
  output logic                  bad_pattern
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);

  logic [7:0]          seg_s1, seg_s;
  logic [DIGITS-1:0]   an_s1, an_s, an_prev;

  sel_state_e          state_q;
  logic [CW-1:0]       cnt_q;

  logic [DIGITS-1:0]   sel;
  logic                an_onehot;
  logic                an_changed;
  logic                settling_now;
  logic [CW-1:0]       run;
  logic                capture;

  logic                pat_ok;
  logic [3:0]          pat_nib;

  logic [4*DIGITS-1:0] buf_val_q, cand_val_q;
  logic [DIGITS-1:0]   buf_dp_q, cand_dp_q;
  logic [DIGITS-1:0]   seen_q;
  logic                bad_q;
  logic [SW-1:0]       stab_q;
  logic                frame_done;

  // Two-flop synchronizers; idle state is all ones (nothing driven).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1  <= '1;
      seg_s   <= '1;
      an_s1   <= '1;
      an_s    <= '1;
      an_prev <= '1;
    end else begin
      seg_s1  <= seg;
      seg_s   <= seg_s1;
      an_s1   <= an;
      an_s    <= an_s1;
      an_prev <= an_s;
    end
  end

  always_comb begin
    sel        = ~an_s;
    an_onehot  = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    an_changed = (an_s != an_prev);
    // run = number of consecutive cycles (including this one) the current select has been
    // stable and one-hot; a change restarts it at 1.
    run = '0;
    if (an_changed) begin
      if (an_onehot) run = CW'(1);
    end else if (state_q == StSettling) begin
      run = cnt_q + CW'(1);
    end
    settling_now = an_changed ? an_onehot : (state_q == StSettling);
    capture      = settling_now && (run == CW'(SETTLE));
    frame_done   = &seen_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWaitSel;
      cnt_q   <= '0;
    end else if (capture) begin
      state_q <= StCaptured;
      cnt_q   <= '0;
    end else if (settling_now) begin
      state_q <= StSettling;
      cnt_q   <= run;
    end else if (an_changed) begin
      state_q <= StWaitSel;
      cnt_q   <= '0;
    end
  end

  seg_decode_lut u_lut (
    .pat    (seg_s[6:0]),
    .ok     (pat_ok),
    .nibble (pat_nib)
  );

  // Frame buffer, candidate qualification and published outputs. The capture branch comes
  // last so a capture coinciding with frame completion lands in the freshly cleared frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_val_q   <= '0;
      buf_dp_q    <= '0;
      cand_val_q  <= '0;
      cand_dp_q   <= '0;
      seen_q      <= '0;
      bad_q       <= 1'b0;
      stab_q      <= '0;
      value       <= '0;
      dp          <= '0;
      value_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      bad_pattern <= 1'b0;

      if (frame_done) begin
        seen_q <= '0;
        bad_q  <= 1'b0;
        if (bad_q) begin
          stab_q <= '0;
        end else if ({buf_val_q, buf_dp_q} != {cand_val_q, cand_dp_q}) begin
          cand_val_q <= buf_val_q;
          cand_dp_q  <= buf_dp_q;
          stab_q     <= SW'(1);
          if (STABLE_FRAMES == 1) begin
            value       <= buf_val_q;
            dp          <= buf_dp_q;
            value_valid <= 1'b1;
          end
        end else if (stab_q < SW'(STABLE_FRAMES)) begin
          stab_q <= stab_q + SW'(1);
          if (stab_q + SW'(1) == SW'(STABLE_FRAMES)) begin
            value       <= cand_val_q;
            dp          <= cand_dp_q;
            value_valid <= 1'b1;
          end
        end
      end

      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            buf_val_q[4*i +: 4] <= pat_nib;
            buf_dp_q[i]         <= ~seg_s[SEG_DP];
            seen_q[i]           <= 1'b1;
          end
        end
        if (!pat_ok) begin
          bad_q       <= 1'b1;
          bad_pattern <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int DIGITS = 4;
  localparam int SETTLE = 4;
  localparam int SF     = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                value_valid;
  logic                bad_pattern;

  seg_scan_decoder #(
    .DIGITS        (DIGITS),
    .SETTLE        (SETTLE),
    .STABLE_FRAMES (SF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .dp          (dp),
    .value_valid (value_valid),
    .bad_pattern (bad_pattern)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vv_seen = 0;
  int bp_seen = 0;

  always @(negedge clk) begin
    if (value_valid === 1'b1) vv_seen++;
    if (bad_pattern === 1'b1) bp_seen++;
  end

  // Reference model: glyph table, per-digit frame slots, candidate and stability count.
  logic [7:0] pat_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int m_nib  [DIGITS];
  int m_dpb  [DIGITS];
  bit m_seen [DIGITS];
  bit m_bad;
  int m_cand_val, m_cand_dp, m_stab, m_val, m_dp;
  int exp_vv = 0;
  int exp_bp = 0;

  function automatic int decode(input logic [6:0] p);
    for (int k = 0; k < 16; k++) begin
      if (pat_tab[k][6:0] == p) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_nib[i] = 0; m_dpb[i] = 0; m_seen[i] = 0;
    end
    m_bad = 0; m_cand_val = 0; m_cand_dp = 0; m_stab = 0; m_val = 0; m_dp = 0;
  endtask

  task automatic model_capture(input int d, input logic [7:0] p);
    int n;
    bit all;
    int fv, fd;
    n = decode(p[6:0]);
    if (n < 0) begin
      m_bad = 1;
      exp_bp++;
      n = 0;
    end
    m_nib[d]  = n;
    m_dpb[d]  = p[7] ? 0 : 1;
    m_seen[d] = 1;
    all = 1;
    for (int i = 0; i < DIGITS; i++) if (!m_seen[i]) all = 0;
    if (all) begin
      fv = 0; fd = 0;
      for (int i = 0; i < DIGITS; i++) begin
        fv += m_nib[i] * (1 << (4 * i));
        fd += m_dpb[i] * (1 << i);
      end
      if (m_bad) begin
        m_stab = 0;
      end else if (fv != m_cand_val || fd != m_cand_dp) begin
        m_cand_val = fv;
        m_cand_dp  = fd;
        m_stab     = 1;
      end else if (m_stab < SF) begin
        m_stab++;
        if (m_stab == SF) begin
          m_val = m_cand_val;
          m_dp  = m_cand_dp;
          exp_vv++;
        end
      end
      for (int i = 0; i < DIGITS; i++) m_seen[i] = 0;
      m_bad = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    an  = '1;
    seg = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input int d, input logic [7:0] p, input int hold);
    logic [DIGITS-1:0] one;
    one = 1;
    an  = ~(one << d);
    seg = p;
    repeat (hold) @(posedge clk);
    #1;
    if (hold >= SETTLE) model_capture(d, p);
  endtask

  task automatic scan_frame(input logic [8*DIGITS-1:0] pats, input logic [4*DIGITS-1:0] holds);
    for (int d = 0; d < DIGITS; d++) step(d, pats[8*d +: 8], int'(holds[4*d +: 4]));
  endtask

  task automatic check_frame(input string tag);
    idle(6);
    check({tag, " value_valid count"}, vv_seen, exp_vv);
    check({tag, " bad_pattern count"}, bp_seen, exp_bp);
    check({tag, " value"}, value, m_val);
    check({tag, " dp"}, dp, m_dp);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    idle(3);
  endtask

  localparam logic [8*DIGITS-1:0] P1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
  localparam logic [8*DIGITS-1:0] PBAD2 = {8'hF9, 8'hFF, 8'hB0, 8'h99};
  localparam logic [8*DIGITS-1:0] PDP0  = {8'hF9, 8'hA4, 8'hB0, 8'h40};
  localparam logic [4*DIGITS-1:0] HFULL = 16'hAAAA;
  localparam logic [4*DIGITS-1:0] HSHORT1 = 16'hAA3A;

  initial begin
    logic [8*DIGITS-1:0] rp;
    logic [4*DIGITS-1:0] rh;
    logic [7:0]          p;
    int                  hv, reps;

    rst = 1'b1;
    an  = '1;
    seg = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset value", value, 0);
    check("reset dp", dp, 0);
    check("reset value_valid", value_valid, 0);
    check("reset bad_pattern", bad_pattern, 0);
    rst = 1'b0;
    idle(2);

    // Two identical frames publish once; a third adds no pulse.
    scan_frame(P1234, HFULL);
    check_frame("t1 f1");
    scan_frame(P1234, HFULL);
    check_frame("t1 f2");
    check("t1 value 1234", value, 32'h1234);
    scan_frame(P1234, HFULL);
    check_frame("t1 f3");

    // Reset asserted between edges in the middle of a digit.
    step(0, 8'h99, 10);
    an  = 4'hD;
    seg = 8'hB0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst value", value, 0);
    check("midrst dp", dp, 0);
    check("midrst value_valid", value_valid, 0);
    check("midrst bad_pattern", bad_pattern, 0);
    an  = '1;
    seg = '1;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    idle(4);
    scan_frame(P1234, HFULL);
    check_frame("t6 f1");
    scan_frame(P1234, HFULL);
    check_frame("t6 f2");

    // Undecodable digit discards the frame.
    do_reset();
    scan_frame(PBAD2, HFULL);
    check_frame("t2 bad");
    check("t2 value held 0", value, 0);
    scan_frame(P1234, HFULL);
    check_frame("t2 f2");
    scan_frame(P1234, HFULL);
    check_frame("t2 f3");

    // Digit 1 held below SETTLE never completes a frame.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      scan_frame(P1234, HSHORT1);
      check_frame("t3 short");
    end

    // Two digits selected at once: no capture.
    do_reset();
    an  = 4'hC;
    seg = 8'hC0;
    repeat (10) @(posedge clk);
    #1;
    check("t4 state", 32'(dut.state_q), 32'(seg_pkg::StWaitSel));
    check_frame("t4 multi");

    // Digit 0 shows 0 with its decimal point lit.
    do_reset();
    scan_frame(PDP0, HFULL);
    check_frame("t5 f1");
    scan_frame(PDP0, HFULL);
    check_frame("t5 f2");
    check("t5 value", value, 32'h1230);
    check("t5 dp", dp, 32'h1);

    // Randomized frames: occasional junk patterns, dp bits, short and boundary holds.
    for (int g = 0; g < 10; g++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 9) == 0) begin
          p = 8'($urandom_range(0, 255));
        end else begin
          p = pat_tab[$urandom_range(0, 15)];
          if ($urandom_range(0, 3) == 0) p[7] = 1'b0;
        end
        rp[8*d +: 8] = p;
        hv = $urandom_range(0, 7);
        rh[4*d +: 4] = (hv == 0) ? 4'd3 : (hv == 1) ? 4'd4 : 4'd10;
      end
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        scan_frame(rp, rh);
        check_frame("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
